seven_seg_scan_driver: RTL and testbench

// - Display-side consumer of the data-input block. Takes BCD digits (ones/tens/hundreds) and a sign,
//   and drives the Basys3 4-digit common-anode 7-segment display by time-multiplexing the digits.
// - Digits are latched once per frame, so a frame never mixes old and new values.
// - Optional leading-zero blanking.
// - Optional blinking of the digit currently being edited (cursor).

---
 rtl/seven_seg_pkg.sv | 39 +++
 rtl/seg_decoder.sv | 16 +
 rtl/seven_seg_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// - Active-low segment patterns {g,f,e,d,c,b,a}: blank, minus, 'E' and the BCD digit table.
// - Counter-width helper and default counter widths (DIV_W, BLINK_W).
// - Shadow-register bundle latched once per display frame.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Codes 10..15 are not BCD and show 'E'.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_E, SEG_E, SEG_E, SEG_E, SEG_E, SEG_E
    };

    // Bits needed to hold counts 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_CLK_HZ   = 100_000_000;
    localparam int unsigned DEF_SCAN_HZ  = 1000;
    localparam int unsigned DEF_BLINK_HZ = 2;

    localparam int unsigned DIV_W   = cnt_width(DEF_CLK_HZ / DEF_SCAN_HZ);
    localparam int unsigned BLINK_W = cnt_width(DEF_CLK_HZ / (2 * DEF_BLINK_HZ));

    typedef struct packed {
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] hundreds;
        logic       sign;
        logic [1:0] cursor;
        logic       cursor_en;
        logic       blank_lz;
    } shadow_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
// - bcd  in   4  digit code; 10..15 decode to 'E'
// - seg  out  7  active-low pattern {g,f,e,d,c,b,a}
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are latched into shadow registers once per frame so a frame never mixes values.
// Supports leading-zero blanking and a blinking edit cursor.
// Ports:
// - clk          in   1  system clock
// - reset        in   1  asynchronous active-low reset
// - ones_in      in   4  BCD ones digit
// - tens_in      in   4  BCD tens digit
// - hundreds_in  in   4  BCD hundreds digit
// - sign_in      in   1  1 = negative
// - cursor       in   2  digit under edit: 0 ones, 1 tens, 2 hundreds, 3 sign
// - cursor_en    in   1  enable cursor blinking
// - blank_lz     in   1  enable leading-zero blanking
// - seg          out  7  active-low segments {g,f,e,d,c,b,a}
// - dp           out  1  active-low decimal point, held off
// - an           out  4  active-low anodes, an[0] = ones ... an[3] = sign
// - frame_tick   out  1  pulse in the cycle the shadow registers load
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
    parameter int unsigned SCAN_HZ  = DEF_SCAN_HZ,
    parameter int unsigned BLINK_HZ = DEF_BLINK_HZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones_in,
    input  logic [3:0] tens_in,
    input  logic [3:0] hundreds_in,
    input  logic       sign_in,
    input  logic [1:0] cursor,
    input  logic       cursor_en,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned DIV_CW  = cnt_width(DIV);
    localparam int unsigned HALF_CW = cnt_width(HALF);

    localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(DIV - 1);
    localparam logic [HALF_CW-1:0] HALF_LAST = HALF_CW'(HALF - 1);

    localparam logic [1:0] IDX_ONES = 2'd0;
    localparam logic [1:0] IDX_TENS = 2'd1;
    localparam logic [1:0] IDX_HUND = 2'd2;
    localparam logic [1:0] IDX_SIGN = 2'd3;

    logic [DIV_CW-1:0]  presc_q, presc_d;
    logic [HALF_CW-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [1:0]         idx_q, idx_d;
    logic               started_q, started_d;
    shadow_t            shadow_q, shadow_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic       scan_tick;
    logic       blink_tog;
    logic       load;
    logic [3:0] digit_sel;
    logic [6:0] digit_seg;

    assign scan_tick = (presc_q == DIV_LAST);
    assign blink_tog = (blink_cnt_q == HALF_LAST);
    // The very first scan tick after reset opens a frame without advancing the index.
    assign load      = scan_tick && (!started_q || idx_q == IDX_SIGN);

    always_comb begin
        presc_d       = scan_tick ? '0 : presc_q + 1'b1;
        blink_cnt_d   = blink_tog ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_tog ? ~blink_phase_q : blink_phase_q;
        idx_d         = idx_q;
        started_d     = started_q;
        shadow_d      = shadow_q;
        if (scan_tick) begin
            started_d = 1'b1;
            idx_d     = started_q ? idx_q + 2'd1 : IDX_ONES;
        end
        if (load) begin
            shadow_d = '{
                ones:      ones_in,
                tens:      tens_in,
                hundreds:  hundreds_in,
                sign:      sign_in,
                cursor:    cursor,
                cursor_en: cursor_en,
                blank_lz:  blank_lz
            };
        end
    end

    always_comb begin
        digit_sel = shadow_q.ones;
        unique case (idx_q)
            IDX_ONES: digit_sel = shadow_q.ones;
            IDX_TENS: digit_sel = shadow_q.tens;
            IDX_HUND: digit_sel = shadow_q.hundreds;
            IDX_SIGN: digit_sel = 4'd0;
            default:  digit_sel = shadow_q.ones;
        endcase
    end

    seg_decoder u_seg_decoder (
        .bcd (digit_sel),
        .seg (digit_seg)
    );

    // Output mux works from registered state, so outputs trail the index by one clock.
    always_comb begin
        seg_d = digit_seg;
        if (idx_q == IDX_SIGN) begin
            seg_d = shadow_q.sign ? SEG_MINUS : SEG_BLANK;
        end
        if (shadow_q.blank_lz && shadow_q.hundreds == 4'd0) begin
            if (idx_q == IDX_HUND) begin
                seg_d = SEG_BLANK;
            end
            if (idx_q == IDX_TENS && shadow_q.tens == 4'd0) begin
                seg_d = SEG_BLANK;
            end
        end
        if (shadow_q.cursor_en && blink_phase_q && idx_q == shadow_q.cursor) begin
            seg_d = SEG_BLANK;
        end
        an_d = ~(4'b0001 << idx_q);
        if (!started_q) begin
            seg_d = SEG_BLANK;
            an_d  = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            idx_q         <= IDX_ONES;
            started_q     <= 1'b0;
            shadow_q      <= '0;
            seg_q         <= SEG_BLANK;
            an_q          <= 4'b1111;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            started_q     <= started_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = 1'b1;
    assign frame_tick = load;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: CLK_HZ=16, SCAN_HZ=4 (4 clks/slot),
// BLINK_HZ=1 (blink phase toggles every 8 clks).
module tb_seven_seg_scan_driver;

    localparam int SLOT = 4;
    localparam int HALF = 8;

    logic       clk;
    logic       reset;
    logic [3:0] ones_in, tens_in, hundreds_in;
    logic       sign_in;
    logic [1:0] cursor;
    logic       cursor_en, blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;
    int cyc;

    logic [10:0] sb_q[$];

    seven_seg_scan_driver #(
        .CLK_HZ   (16),
        .SCAN_HZ  (4),
        .BLINK_HZ (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ones_in     (ones_in),
        .tens_in     (tens_in),
        .hundreds_in (hundreds_in),
        .sign_in     (sign_in),
        .cursor      (cursor),
        .cursor_en   (cursor_en),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] m_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    function automatic logic [6:0] m_slot(input int idx, input logic ph);
        logic [6:0] s;
        case (idx)
            0: s = m_dec(ones_in);
            1: s = (blank_lz && hundreds_in == 0 && tens_in == 0) ? 7'h7F : m_dec(tens_in);
            2: s = (blank_lz && hundreds_in == 0) ? 7'h7F : m_dec(hundreds_in);
            default: s = sign_in ? 7'h3F : 7'h7F;
        endcase
        if (cursor_en && ph && int'(cursor) == idx) s = 7'h7F;
        return s;
    endfunction

    // Called at the negedge where frame_tick is seen; load edge is cyc+1.
    task automatic push_frame(input int c);
        logic [3:0] a;
        logic       ph;
        for (int i = 0; i < 4; i++) begin
            a    = 4'b1111;
            a[i] = 1'b0;
            ph   = (((c + 1 + SLOT * i) / HALF) % 2) == 1;
            sb_q.push_back({a, m_slot(i, ph)});
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL frame_wait: frame_tick not seen within 40 clks (actual 0, required 1)");
        end
    endtask

    task automatic run_frames(input int n);
        bit ok;
        for (int f = 0; f < n; f++) begin
            wait_frame(ok);
            if (ok) push_frame(cyc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 48 && sb_q.size() > 0; i++) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected slots left, required 0", sb_q.size());
        end
    endtask

    // Scoreboard monitor: each anode change pops one expected slot.
    initial begin
        logic [3:0]  prev_an;
        logic [10:0] e;
        int          run;
        bit          tracking;
        prev_an  = 4'hF;
        run      = 0;
        tracking = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_an  = 4'hF;
                run      = 0;
                tracking = 0;
            end else if (an !== prev_an) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    tests++;
                    if (an !== e[10:7]) begin
                        fails++;
                        $display("FAIL slot_an: actual %b required %b", an, e[10:7]);
                    end
                    tests++;
                    if (seg !== e[6:0] || dp !== 1'b1) begin
                        fails++;
                        $display("FAIL slot_seg: an %b actual seg %h dp %b required seg %h dp 1",
                                 an, seg, dp, e[6:0]);
                    end
                    if (tracking) begin
                        tests++;
                        if (run != SLOT) begin
                            fails++;
                            $display("FAIL slot_len: actual %0d clks required %0d", run, SLOT);
                        end
                    end
                    tracking = 1;
                end else begin
                    tracking = 0;
                end
                run     = 1;
                prev_an = an;
            end else begin
                run++;
            end
        end
    end

    task automatic set_inputs(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                              input logic s, input logic [1:0] cur, input logic cen,
                              input logic lz);
        hundreds_in = h;
        tens_in     = t;
        ones_in     = o;
        sign_in     = s;
        cursor      = cur;
        cursor_en   = cen;
        blank_lz    = lz;
    endtask

    task automatic test_reset();
        set_inputs(4'd1, 4'd2, 4'd3, 1'b1, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: an %b seg %h dp %b ft %b required 1111 7f 1 0",
                     an, seg, dp, frame_tick);
        end
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (an !== ((k == 5) ? 4'b1110 : 4'b1111)) begin
                fails++;
                $display("FAIL first_anode: clk %0d actual %b required %b", k, an,
                         (k == 5) ? 4'b1110 : 4'b1111);
            end
            tests++;
            if (frame_tick !== (k == 3)) begin
                fails++;
                $display("FAIL first_frame_tick: clk %0d actual %b required %b", k,
                         frame_tick, (k == 3));
            end
        end
        tests++;
        if (seg !== 7'h30) begin
            fails++;
            $display("FAIL first_seg: actual %h required 30", seg);
        end
    endtask

    task automatic test_basic();
        set_inputs(4'd1, 4'd2, 4'd3, 1'b1, 2'd0, 1'b0, 1'b0);
        run_frames(2);
    endtask

    task automatic test_blanking();
        set_inputs(4'd0, 4'd0, 4'd7, 1'b0, 2'd0, 1'b0, 1'b1);
        run_frames(2);
        set_inputs(4'd0, 4'd4, 4'd0, 1'b1, 2'd0, 1'b0, 1'b1);
        run_frames(1);
    endtask

    task automatic test_mid_frame();
        set_inputs(4'd0, 4'd1, 4'd3, 1'b0, 2'd0, 1'b0, 1'b0);
        run_frames(1);
        repeat (6) @(posedge clk);
        #1;
        ones_in = 4'd9;
        run_frames(1);
    endtask

    task automatic test_cursor();
        set_inputs(4'd0, 4'd5, 4'd3, 1'b1, 2'd1, 1'b1, 1'b0);
        run_frames(2);
        for (int c = 0; c < 4; c++) begin
            cursor = 2'(c);
            run_frames(1);
        end
        cursor_en = 1'b0;
        run_frames(1);
    endtask

    task automatic test_error_and_async_reset();
        set_inputs(4'd0, 4'd0, 4'hC, 1'b0, 2'd0, 1'b0, 1'b0);
        run_frames(1);
        drain();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: an %b seg %h ft %b required 1111 7f 0", an, seg, frame_tick);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (an !== 4'b1110 || seg !== 7'h06) begin
            fails++;
            $display("FAIL restart: an %b seg %h required 1110 06", an, seg);
        end
    endtask

    initial begin
        reset = 1'b0;
        set_inputs(4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_blanking();
        test_mid_frame();
        test_cursor();
        drain();
        test_error_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
